// File: rtl/adc_link_pkg.sv
// Shared types and constants for the serial dual-ADC link.
// The frame transmitter and its receive-side bench sources both use them.
package adc_link_pkg;

  localparam int ADC_FRAME_LEN  = 16;
  localparam int ADC_LEAD_ZEROS = 2;
  localparam int ADC_DATA_W     = 12;

  typedef logic [11:0] adc_sample_t;

  typedef struct packed {
    adc_sample_t b1;
    adc_sample_t b0;
    adc_sample_t a1;
    adc_sample_t a0;
  } adc_quad_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } adc_tx_state_t;

  // Pattern mode derives all four lanes from one ramp value so a receiver can cross-check them.
  function automatic adc_quad_t rampQuad(input adc_sample_t r);
    adc_quad_t q;
    q.a0 = r;
    q.a1 = ~r;
    q.b0 = r + 12'h400;
    q.b1 = r ^ 12'hAAA;
    return q;
  endfunction

endpackage

// File: rtl/adc_lane_shifter.sv
// One output lane: parallel-load, MSB-first shifter that emits zeros outside the data window.
// The parent owns the bit counter and tells each lane which frame bit is being driven.
module adc_lane_shifter #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 2,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [CNT_W-1:0]  i_bitIdx,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit
);

  logic [DATA_W-1:0] r_shreg;
  logic              r_bit;
  logic [DATA_W-1:0] w_src;
  logic              w_inData;

  always_comb begin
    w_src    = i_load ? i_data : r_shreg;
    w_inData = (int'(i_bitIdx) >= LEAD_ZEROS) && (int'(i_bitIdx) < LEAD_ZEROS + DATA_W);
  end

  // The shift register only moves while a data bit is emitted, so padding bits leave it intact.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_bit   <= 1'b0;
    end else if (i_clear) begin
      r_bit <= 1'b0;
    end else if (i_load || i_advance) begin
      r_bit <= w_inData & w_src[DATA_W-1];
      if (w_inData) r_shreg <= {w_src[DATA_W-2:0], 1'b0};
      else          r_shreg <= w_src;
    end
  end

  assign o_bit = r_bit;

endmodule

// File: rtl/adc_frame_tx.sv
// Serial-ADC frame transmitter: drives four lanes MSB-first on each chip-select frame,
// sourcing samples from a one-deep hold register or from an internal ramp pattern.
module adc_frame_tx
  import adc_link_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 2,
  parameter int FRAME_LEN  = 16,
  parameter int RAMP_STEP  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ad_cs_n,
  output logic [1:0]          ad_sdata_a,
  output logic [1:0]          ad_sdata_b,
  input  logic [4*DATA_W-1:0] smp_data,
  input  logic                smp_valid,
  output logic                smp_ready,
  input  logic                pattern_en,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         underrun_cnt
);

  localparam int                CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_LEN - 1);

  adc_tx_state_t    r_state;
  logic             r_csPrev;
  logic [CNT_W-1:0] r_bitCnt;
  logic             r_busy;
  logic [15:0]      r_frameCnt;
  logic [15:0]      r_underrunCnt;
  adc_sample_t      r_ramp;
  adc_quad_t        r_hold;
  logic             r_holdFull;
  adc_quad_t        r_lastSent;

  logic             w_start;
  logic             w_advance;
  logic             w_clear;
  logic             w_accept;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] w_bitIdx;
  adc_quad_t        w_loadQuad;
  logic             w_a0, w_a1, w_b0, w_b1;

  // A frame starts only on a fresh cs fall seen from IDLE; holding cs low never re-triggers.
  always_comb begin
    w_start    = (r_state == ST_IDLE) && !ad_cs_n && r_csPrev;
    w_nextCnt  = r_bitCnt + 1'b1;
    w_advance  = (r_state == ST_SHIFT) && !ad_cs_n && (r_bitCnt != LAST_BIT);
    w_clear    = (r_state == ST_SHIFT) && !w_advance;
    w_bitIdx   = w_start ? '0 : w_nextCnt;
    w_accept   = smp_valid && !r_holdFull;
    if (pattern_en)      w_loadQuad = rampQuad(r_ramp);
    else if (r_holdFull) w_loadQuad = r_hold;
    else                 w_loadQuad = r_lastSent;
  end

  // Accept and frame-load of the hold register are exclusive: accept needs it empty, load needs it full.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_csPrev      <= 1'b1;
      r_bitCnt      <= '0;
      r_busy        <= 1'b0;
      r_frameCnt    <= '0;
      r_underrunCnt <= '0;
      r_ramp        <= '0;
      r_hold        <= '0;
      r_holdFull    <= 1'b0;
      r_lastSent    <= '0;
    end else begin
      r_csPrev <= ad_cs_n;
      if (w_accept) begin
        r_hold     <= adc_quad_t'(smp_data);
        r_holdFull <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_SHIFT;
            r_bitCnt <= '0;
            r_busy   <= 1'b1;
            if (pattern_en) begin
              r_ramp <= r_ramp + adc_sample_t'(RAMP_STEP);
            end else if (r_holdFull) begin
              r_holdFull <= 1'b0;
              r_lastSent <= r_hold;
            end else if (r_underrunCnt != 16'hFFFF) begin
              r_underrunCnt <= r_underrunCnt + 16'd1;
            end
          end
        end
        ST_SHIFT: begin
          if (ad_cs_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_bitCnt == LAST_BIT) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_bitCnt <= w_nextCnt;
            if (w_nextCnt == LAST_BIT) r_frameCnt <= r_frameCnt + 16'd1;
          end
        end
        ST_DONE: begin
          if (ad_cs_n) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  adc_lane_shifter #(.DATA_W(DATA_W), .LEAD_ZEROS(LEAD_ZEROS), .CNT_W(CNT_W)) uLaneA0 (
    .clk(clk), .reset_n(reset_n), .i_clear(w_clear), .i_load(w_start), .i_advance(w_advance),
    .i_bitIdx(w_bitIdx), .i_data(w_loadQuad.a0), .o_bit(w_a0)
  );

  adc_lane_shifter #(.DATA_W(DATA_W), .LEAD_ZEROS(LEAD_ZEROS), .CNT_W(CNT_W)) uLaneA1 (
    .clk(clk), .reset_n(reset_n), .i_clear(w_clear), .i_load(w_start), .i_advance(w_advance),
    .i_bitIdx(w_bitIdx), .i_data(w_loadQuad.a1), .o_bit(w_a1)
  );

  adc_lane_shifter #(.DATA_W(DATA_W), .LEAD_ZEROS(LEAD_ZEROS), .CNT_W(CNT_W)) uLaneB0 (
    .clk(clk), .reset_n(reset_n), .i_clear(w_clear), .i_load(w_start), .i_advance(w_advance),
    .i_bitIdx(w_bitIdx), .i_data(w_loadQuad.b0), .o_bit(w_b0)
  );

  adc_lane_shifter #(.DATA_W(DATA_W), .LEAD_ZEROS(LEAD_ZEROS), .CNT_W(CNT_W)) uLaneB1 (
    .clk(clk), .reset_n(reset_n), .i_clear(w_clear), .i_load(w_start), .i_advance(w_advance),
    .i_bitIdx(w_bitIdx), .i_data(w_loadQuad.b1), .o_bit(w_b1)
  );

  assign ad_sdata_a   = {w_a1, w_a0};
  assign ad_sdata_b   = {w_b1, w_b0};
  assign smp_ready    = !r_holdFull;
  assign busy         = r_busy;
  assign frame_cnt    = r_frameCnt;
  assign underrun_cnt = r_underrunCnt;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Bench for adc_frame_tx: directed scenarios plus randomized frames, checked against
// a frame-level model that predicts each lane's 16-bit serial word.
module tb_adc_frame_tx;
  import adc_link_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ad_cs_n;
  logic [1:0]  ad_sdata_a;
  logic [1:0]  ad_sdata_b;
  logic [47:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic        pattern_en;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] underrun_cnt;

  int total = 0;
  int bad   = 0;

  adc_quad_t   mHold;
  adc_quad_t   mLast;
  logic        mHoldFull;
  logic [11:0] mRamp;
  int          mFrames;
  int          mUnder;
  adc_quad_t   curExp;
  logic [15:0] got [4];

  adc_frame_tx dut (
    .clk(clk), .reset_n(reset_n), .ad_cs_n(ad_cs_n),
    .ad_sdata_a(ad_sdata_a), .ad_sdata_b(ad_sdata_b),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .pattern_en(pattern_en), .busy(busy),
    .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two leading zeros, twelve data bits MSB-first, two trailing zeros.
  function automatic logic [15:0] expWord(input logic [11:0] v);
    return {2'b00, v, 2'b00};
  endfunction

  function automatic logic [11:0] laneOf(input adc_quad_t q, input int l);
    case (l)
      0:       return q.a0;
      1:       return q.a1;
      2:       return q.b0;
      default: return q.b1;
    endcase
  endfunction

  task automatic modelReset();
    mHold = '0; mLast = '0; mHoldFull = 1'b0; mRamp = '0; mFrames = 0; mUnder = 0;
  endtask

  task automatic push(input logic [47:0] d);
    @(negedge clk);
    smp_valid = 1'b1;
    smp_data  = d;
    check("ready before push", {31'd0, smp_ready}, {31'd0, !mHoldFull});
    @(posedge clk);
    if (!mHoldFull) begin
      mHold     = adc_quad_t'(d);
      mHoldFull = 1'b1;
    end
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic beginFrame();
    if (pattern_en) begin
      curExp.a0 = mRamp;
      curExp.a1 = ~mRamp;
      curExp.b0 = mRamp + 12'h400;
      curExp.b1 = mRamp ^ 12'hAAA;
      mRamp     = mRamp + 12'd1;
    end else if (mHoldFull) begin
      curExp    = mHold;
      mLast     = mHold;
      mHoldFull = 1'b0;
    end else begin
      curExp = mLast;
      if (mUnder < 65535) mUnder++;
    end
    @(negedge clk);
    ad_cs_n = 1'b0;
    @(posedge clk);
    for (int l = 0; l < 4; l++) got[l] = '0;
  endtask

  task automatic collectBits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got[0][15-i] = ad_sdata_a[0];
      got[1][15-i] = ad_sdata_a[1];
      got[2][15-i] = ad_sdata_b[0];
      got[3][15-i] = ad_sdata_b[1];
      check($sformatf("busy bit%0d", i), {31'd0, busy}, 32'd1);
      if (i == 0) check("ready at cycle1", {31'd0, smp_ready}, {31'd0, !mHoldFull});
    end
  endtask

  task automatic compareWords(input int nbits);
    for (int l = 0; l < 4; l++)
      check($sformatf("lane%0d word", l), {16'd0, got[l] >> (16 - nbits)},
            {16'd0, expWord(laneOf(curExp, l)) >> (16 - nbits)});
  endtask

  task automatic fullFrame();
    beginFrame();
    collectBits(16);
    compareWords(16);
    mFrames++;
    @(negedge clk);
    check("lanes idle after frame", {28'd0, ad_sdata_b, ad_sdata_a}, 32'd0);
    check("busy after frame", {31'd0, busy}, 32'd0);
    check("frame_cnt", {16'd0, frame_cnt}, mFrames & 32'hFFFF);
    check("underrun_cnt", {16'd0, underrun_cnt}, mUnder);
    ad_cs_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic [63:0] rnd;
    reset_n = 1'b0; ad_cs_n = 1'b1; smp_valid = 1'b0; smp_data = '0; pattern_en = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset lanes", {28'd0, ad_sdata_b, ad_sdata_a}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ready", {31'd0, smp_ready}, 32'd1);
    check("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("reset underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);

    push({12'h123, 12'h456, 12'h789, 12'hABC});
    fullFrame();
    check("a0 literal word", {16'd0, got[0]}, 32'h2AF0);

    fullFrame();
    check("underrun repeat a0", {16'd0, got[0]}, 32'h2AF0);

    // Abort: cs rises during cycle 6, lanes must be quiet from cycle 7.
    push({12'h321, 12'h654, 12'h987, 12'hCBA});
    beginFrame();
    collectBits(6);
    compareWords(6);
    ad_cs_n = 1'b1;
    @(negedge clk);
    check("abort lanes", {28'd0, ad_sdata_b, ad_sdata_a}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort frame_cnt", {16'd0, frame_cnt}, mFrames);
    fullFrame();

    // cs held low for 40 cycles yields exactly one frame.
    beginFrame();
    collectBits(16);
    compareWords(16);
    mFrames++;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check($sformatf("hold-low quiet %0d", i), {27'd0, busy, ad_sdata_b, ad_sdata_a}, 32'd0);
    end
    check("hold-low frame_cnt", {16'd0, frame_cnt}, mFrames);
    ad_cs_n = 1'b1;
    @(posedge clk);

    // Reset during cycle 8 with a fresh sample sitting in the hold register.
    push({12'h111, 12'h222, 12'h333, 12'h444});
    beginFrame();
    collectBits(7);
    smp_valid = 1'b1;
    smp_data  = {12'h555, 12'h666, 12'h777, 12'h888};
    @(posedge clk);
    @(negedge clk);
    smp_valid = 1'b0;
    check("hold full before reset", {31'd0, smp_ready}, 32'd0);
    reset_n = 1'b0;
    ad_cs_n = 1'b1;
    @(negedge clk);
    check("midframe reset lanes", {28'd0, ad_sdata_b, ad_sdata_a}, 32'd0);
    check("midframe reset busy", {31'd0, busy}, 32'd0);
    check("midframe reset ready", {31'd0, smp_ready}, 32'd1);
    check("midframe reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("midframe reset underrun", {16'd0, underrun_cnt}, 32'd0);
    reset_n = 1'b1;
    modelReset();
    @(posedge clk);
    fullFrame();
    check("post-reset zero data", {16'd0, got[0]}, 32'd0);

    pattern_en = 1'b1;
    fullFrame();
    check("pattern f0 a0", {16'd0, got[0]}, 32'h0000);
    check("pattern f0 a1", {16'd0, got[1]}, 32'h3FFC);
    check("pattern f0 b0", {16'd0, got[2]}, 32'h1000);
    check("pattern f0 b1", {16'd0, got[3]}, 32'h2AA8);
    fullFrame();
    check("pattern f1 a0", {16'd0, got[0]}, 32'h0004);
    fullFrame();
    check("pattern f2 a0", {16'd0, got[0]}, 32'h0008);

    for (int n = 0; n < 12; n++) begin
      pattern_en = ($urandom_range(0, 3) == 0);
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        rnd = {$urandom(), $urandom()};
        push(rnd[47:0]);
      end
      fullFrame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
